// File: rtl/dff_pipe_ctrl_pkg.sv
// Shared defaults and helpers for the dff_pipe_ctrl fixed-latency delay line.
package dff_pipe_ctrl_pkg;

   localparam int DEF_BW_DATA = 32;
   localparam int DEF_DEPTH   = 4;
   localparam int DEF_N_SYNC  = 2;

   // Occupancy counter width: must represent 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/dff_pipe_ctrl_if.sv
// Data/control bundle of the delay line; master drives inputs, slave (the pipe) drives outputs.
interface dff_pipe_ctrl_if #(
   parameter int BW_DATA = dff_pipe_ctrl_pkg::DEF_BW_DATA,
   parameter int CNT_W   = dff_pipe_ctrl_pkg::cnt_w(dff_pipe_ctrl_pkg::DEF_DEPTH)
);
   logic [BW_DATA-1:0] i_d;
   logic               i_vld;
   logic               i_en;
   logic               i_clr;
   logic [BW_DATA-1:0] o_q;
   logic               o_vld;
   logic [CNT_W-1:0]   o_cnt;
   logic               o_rst_done;

   modport master (
      output i_d, i_vld, i_en, i_clr,
      input  o_q, o_vld, o_cnt, o_rst_done
   );

   modport slave (
      input  i_d, i_vld, i_en, i_clr,
      output o_q, o_vld, o_cnt, o_rst_done
   );
endinterface

// File: rtl/dff_pipe_ctrl_rstn_sync.sv
// Reset synchronizer: asserts asynchronously, releases on the N_SYNC-th clock edge.
module rstn_sync #(
   parameter int N_SYNC = 2
) (
   input  logic i_clk,
   input  logic i_rstn,
   output logic o_rstn_s
);
   logic [N_SYNC-1:0] chain;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) chain <= '0;
      else         chain <= {chain[N_SYNC-2:0], 1'b1};
   end

   assign o_rstn_s = chain[N_SYNC-1];
endmodule

// File: rtl/dff_pipe_ctrl.sv
// DEPTH-stage delay line with per-stage valid, stall, synchronous flush and occupancy count.
module dff_pipe_ctrl
   import dff_pipe_ctrl_pkg::*;
#(
   parameter int               BW_DATA   = DEF_BW_DATA,
   parameter int               DEPTH     = DEF_DEPTH,
   parameter int               N_SYNC    = DEF_N_SYNC,
   parameter logic [BW_DATA-1:0] RST_VAL = '0,
   parameter bit               GATE_DATA = 1'b0
) (
   input  logic          i_clk,
   input  logic          i_rstn,
   dff_pipe_ctrl_if.slave bus
);
   localparam int CNT_W = cnt_w(DEPTH);

   logic             rstn_s;
   logic [CNT_W-1:0] cnt;
   logic             last_v;

   rstn_sync #(.N_SYNC(N_SYNC)) u_rstn_sync (
      .i_clk    (i_clk),
      .i_rstn   (i_rstn),
      .o_rstn_s (rstn_s)
   );

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic [BW_DATA-1:0] d_in;
      logic               v_in;
      logic [BW_DATA-1:0] s_r;
      logic               v_r;

      if (k == 0) begin : g_head
         assign d_in = bus.i_d;
         assign v_in = bus.i_vld;
      end else begin : g_tail
         assign d_in = g_stage[k-1].s_r;
         assign v_in = g_stage[k-1].v_r;
      end

      always_ff @(posedge i_clk or negedge rstn_s) begin
         if (!rstn_s) begin
            s_r <= RST_VAL;
            v_r <= 1'b0;
         end else if (bus.i_clr) begin
            s_r <= RST_VAL;
            v_r <= 1'b0;
         end else if (bus.i_en) begin
            v_r <= v_in;
            // In gated mode bubbles leave the data register untouched.
            if (!GATE_DATA || v_in) s_r <= d_in;
         end
      end
   end

   assign last_v = g_stage[DEPTH-1].v_r;

   always_ff @(posedge i_clk or negedge rstn_s) begin
      if (!rstn_s)          cnt <= '0;
      else if (bus.i_clr)   cnt <= '0;
      else if (bus.i_en)    cnt <= cnt + CNT_W'(bus.i_vld) - CNT_W'(last_v);
   end

   assign bus.o_q        = g_stage[DEPTH-1].s_r;
   assign bus.o_vld      = last_v;
   assign bus.o_cnt      = cnt;
   assign bus.o_rst_done = rstn_s;
endmodule
